muxnx1_scan: RTL and testbench
==============================

MUXNX1_SCAN -- requirements
Module: muxnx1_scan

Interface
REQ-001 Parameter N, default 4: number of input channels; legal range 2..64.
REQ-002 Parameter W, default 1: bits per channel; legal range 1..32.
REQ-003 Parameter DWELL, default 1: cycles per channel in scan mode; legal range 1..255.
REQ-004 Derived SW = max(1, ceil(log2 N)): select and channel-index width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i  input  N*W  channel data; channel k occupies bits [k*W+W-1 : k*W].
REQ-008 s  input  SW  manual channel select; also the scan start channel.
REQ-009 mode  input  1  0 = manual, 1 = scan.
REQ-010 en  input  1  advance/capture enable.
REQ-011 y  output  W  registered selected channel data.
REQ-012 y_valid  output  1  y was captured this cycle.
REQ-013 ch  output  SW  index of the channel currently presented on y.
REQ-014 wrap  output  1  one-cycle pulse when scan pointer wraps N-1 -> 0.
REQ-015 err  output  1  registered flag: manual select out of range (s >= N).

Function
REQ-016 The block SHALL implement a two-state FSM, MANUAL and SCAN, with state register plus pointer ptr (SW bits) and dwell counter dcnt (8 bits).
REQ-017 In MANUAL with en=1 and s<N: next cycle y=i[s], ch=s, y_valid=1, err=0; latency exactly one cycle.
REQ-018 In MANUAL with en=1 and s>=N: next cycle y=0, ch=s, y_valid=1, err=1.
REQ-019 With en=0 in either state: y, ch, err, ptr and dcnt SHALL hold; y_valid=0 and wrap=0 next cycle.
REQ-020 MANUAL -> SCAN when mode=1 on a clock edge: ptr loads s (0 if s>=N), dcnt=0, that edge's capture presents i[ptr-load value]; err=0.
REQ-021 In SCAN with en=1: y=i[ptr], ch=ptr, y_valid=1 every enabled cycle; dcnt increments, and when dcnt reaches DWELL-1 it SHALL clear and ptr SHALL advance.
REQ-022 Pointer advance: ptr=N-1 advances to 0 with wrap=1 in the same cycle the new channel 0 is presented; otherwise ptr+1, wrap=0.
REQ-023 DWELL=1: ptr advances every enabled cycle (full-rate round-robin).
REQ-024 SCAN -> MANUAL when mode=0 on a clock edge: that edge behaves as REQ-017/018 using s; ptr and dcnt clear to 0.
REQ-025 Change of i SHALL be reflected on y only at a capture edge; y SHALL never be combinational from i or s.
REQ-026 err SHALL never assert in SCAN; wrap SHALL never assert in MANUAL.
REQ-027 Non-power-of-2 N: ptr SHALL never take values >= N.

Reset
REQ-028 rst=1 at a clock edge SHALL force state=MANUAL, y=0, ch=0, y_valid=0, wrap=0, err=0, ptr=0, dcnt=0, overriding en and mode.
REQ-029 Reset mid-scan or mid-dwell SHALL discard progress; first post-reset capture follows REQ-017/018 or REQ-020 per mode at that edge.
REQ-030 No output SHALL change asynchronously on rst.

Verification
REQ-031 N=4,W=1,i=4'b1010, manual, en=1, s=3,2,1,0 -> y 1,0,1,0 one cycle after each s, ch tracks s, err=0.
REQ-032 N=5,W=8, manual, s=6 -> next cycle y=0, err=1, y_valid=1; s=4 -> err=0, y=i[4].
REQ-033 N=4,DWELL=3, scan from s=2, en=1 -> ch sequence 2,2,2,3,3,3,0,0,0,1; wrap=1 only on first cycle ch=0.
REQ-034 Scan with en toggled low 2 cycles mid-dwell -> y,ch hold, y_valid=0, dwell resumes with no skipped or extra cycles.
REQ-035 rst asserted mid-scan at ch=3 -> next cycle all outputs 0, state MANUAL; release with mode=1,s=1 -> scan restarts at ch=1.

Source files
------------

// File: rtl/muxnx1_scan.sv
// N-to-1 registered multiplexer with manual channel select and a round-robin
// scan mode that dwells DWELL enabled cycles on each channel.
module muxnx1_scan #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 1,
  localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  i,
  input  logic [SW-1:0]   s,
  input  logic            mode,
  input  logic            en,
  output logic [W-1:0]    y,
  output logic            y_valid,
  output logic [SW-1:0]   ch,
  output logic            wrap,
  output logic            err
);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] data, input logic [SW-1:0] sel);
    logic [W-1:0] res;
    res = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) begin
        res = data[k*W +: W];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t        r_state, w_state_n;
  logic [SW-1:0] r_ptr, w_ptr_n;
  logic [7:0]    r_dcnt, w_dcnt_n;
  logic [W-1:0]  r_y, w_y_n;
  logic [SW-1:0] r_ch, w_ch_n;
  logic          r_valid, w_valid_n;
  logic          r_wrap, w_wrap_n;
  logic          r_err, w_err_n;

  logic          w_s_ok;
  logic [SW-1:0] w_ptr_load;
  logic [W-1:0]  w_man_y;
  logic          w_last;
  logic [SW-1:0] w_ptr_inc;
  logic          w_dwell_done;
  logic [SW-1:0] w_scan_ptr;

  // Extra bit on the compare so N == 2**SW does not truncate to zero.
  assign w_s_ok       = ({1'b0, s} < (SW+1)'(N));
  assign w_ptr_load   = w_s_ok ? s : '0;
  assign w_man_y      = w_s_ok ? pick(i, s) : '0;
  assign w_last       = (r_ptr == SW'(N-1));
  assign w_ptr_inc    = w_last ? '0 : r_ptr + SW'(1);
  assign w_dwell_done = (r_dcnt == 8'(DWELL-1));
  assign w_scan_ptr   = w_dwell_done ? w_ptr_inc : r_ptr;

  assign y       = r_y;
  assign y_valid = r_valid;
  assign ch      = r_ch;
  assign wrap    = r_wrap;
  assign err     = r_err;

  // Next-state, pointer/dwell and capture logic.
  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_dcnt_n  = r_dcnt;
    w_y_n     = r_y;
    w_ch_n    = r_ch;
    w_valid_n = 1'b0;
    w_wrap_n  = 1'b0;
    w_err_n   = r_err;
    case (r_state)
      ST_MANUAL: begin
        if (mode) begin
          w_state_n = ST_SCAN;
          w_ptr_n   = w_ptr_load;
          w_dcnt_n  = 8'd0;
          w_err_n   = 1'b0;
          if (en) begin
            w_y_n     = pick(i, w_ptr_load);
            w_ch_n    = w_ptr_load;
            w_valid_n = 1'b1;
          end else begin
            w_valid_n = 1'b0;
          end
        end else if (en) begin
          w_y_n     = w_man_y;
          w_ch_n    = s;
          w_valid_n = 1'b1;
          w_err_n   = ~w_s_ok;
        end else begin
          w_valid_n = 1'b0;
        end
      end
      ST_SCAN: begin
        w_err_n = 1'b0;
        if (!mode) begin
          w_state_n = ST_MANUAL;
          w_ptr_n   = '0;
          w_dcnt_n  = 8'd0;
          if (en) begin
            w_y_n     = w_man_y;
            w_ch_n    = s;
            w_valid_n = 1'b1;
            w_err_n   = ~w_s_ok;
          end else begin
            w_valid_n = 1'b0;
          end
        end else if (en) begin
          // The presented channel is the post-advance pointer, so wrap and channel 0 coincide.
          w_ptr_n   = w_scan_ptr;
          w_dcnt_n  = w_dwell_done ? 8'd0 : r_dcnt + 8'd1;
          w_wrap_n  = w_dwell_done & w_last;
          w_y_n     = pick(i, w_scan_ptr);
          w_ch_n    = w_scan_ptr;
          w_valid_n = 1'b1;
        end else begin
          w_valid_n = 1'b0;
        end
      end
      default: begin
        w_state_n = ST_MANUAL;
        w_ptr_n   = '0;
        w_dcnt_n  = 8'd0;
      end
    endcase
  end

  // State and output registers; rst is synchronous and overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_MANUAL;
      r_ptr   <= '0;
      r_dcnt  <= 8'd0;
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_dcnt  <= w_dcnt_n;
      r_y     <= w_y_n;
      r_ch    <= w_ch_n;
      r_valid <= w_valid_n;
      r_wrap  <= w_wrap_n;
      r_err   <= w_err_n;
    end
  end

endmodule

// File: tb/tb_muxnx1_scan.sv
// Directed bench for muxnx1_scan: instance a (N=4,W=1,DWELL=3) and
// instance b (N=5,W=8,DWELL=1) share clock and reset.
module tb_muxnx1_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [3:0] i_a = 4'b0000;
  logic [1:0] s_a = 2'd0;
  logic       mode_a = 1'b0, en_a = 1'b0;
  logic       y_a, v_a, w_a, e_a;
  logic [1:0] ch_a;

  logic [39:0] i_b = 40'd0;
  logic [2:0]  s_b = 3'd0;
  logic        mode_b = 1'b0, en_b = 1'b0;
  logic [7:0]  y_b;
  logic        v_b, w_b, e_b;
  logic [2:0]  ch_b;

  int checks = 0;
  int failures = 0;

  logic [3:0] pat_a;
  logic [7:0] chan_b [5];

  muxnx1_scan #(.N(4), .W(1), .DWELL(3)) u_a (
    .clk(clk), .rst(rst), .i(i_a), .s(s_a), .mode(mode_a), .en(en_a),
    .y(y_a), .y_valid(v_a), .ch(ch_a), .wrap(w_a), .err(e_a));

  muxnx1_scan #(.N(5), .W(8), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .i(i_b), .s(s_b), .mode(mode_b), .en(en_b),
    .y(y_b), .y_valid(v_b), .ch(ch_b), .wrap(w_b), .err(e_b));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en_a = 1'b1; mode_a = 1'b1; s_a = 2'd2;
    en_b = 1'b1; mode_b = 1'b1; s_b = 3'd3;
    tick; tick;
    checks++;
    if ({y_a, ch_a, v_a, w_a, e_a} !== 6'd0) begin
      failures++;
      $display("FAIL reset_a: got y=%b ch=%0d v=%b wrap=%b err=%b, want all 0", y_a, ch_a, v_a, w_a, e_a);
    end
    checks++;
    if ({y_b, ch_b, v_b, w_b, e_b} !== 14'd0) begin
      failures++;
      $display("FAIL reset_b: got y=%h ch=%0d v=%b wrap=%b err=%b, want all 0", y_b, ch_b, v_b, w_b, e_b);
    end
    rst = 1'b0; mode_a = 1'b0; en_a = 1'b0; mode_b = 1'b0; en_b = 1'b0;
  endtask

  task automatic test_manual_a;
    pat_a = 4'b1010; i_a = pat_a; mode_a = 1'b0; en_a = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      s_a = 2'(k);
      tick;
      checks++;
      if ({y_a, ch_a, v_a, w_a, e_a} !== {pat_a[k], 2'(k), 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL manual_a s=%0d: got y=%b ch=%0d v=%b wrap=%b err=%b, want y=%b ch=%0d v=1 wrap=0 err=0",
                 k, y_a, ch_a, v_a, w_a, e_a, pat_a[k], k);
      end
    end
  endtask

  task automatic test_manual_b;
    logic [2:0] sv [4];
    logic [7:0] ey [4];
    logic       ee [4];
    sv = '{3'd6, 3'd4, 3'd5, 3'd0};
    ey = '{8'h00, 8'h55, 8'h00, 8'h11};
    ee = '{1'b1, 1'b0, 1'b1, 1'b0};
    mode_b = 1'b0; en_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_b = sv[k];
      tick;
      checks++;
      if ({y_b, ch_b, v_b, w_b, e_b} !== {ey[k], sv[k], 1'b1, 1'b0, ee[k]}) begin
        failures++;
        $display("FAIL manual_b s=%0d: got y=%h ch=%0d v=%b wrap=%b err=%b, want y=%h ch=%0d v=1 wrap=0 err=%b",
                 sv[k], y_b, ch_b, v_b, w_b, e_b, ey[k], sv[k], ee[k]);
      end
    end
  endtask

  task automatic test_hold;
    s_b = 3'd6; en_b = 1'b1;
    tick;
    en_b = 1'b0; s_b = 3'd2;
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if ({y_b, ch_b, v_b, w_b, e_b} !== {8'h00, 3'd6, 1'b0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL hold_b cyc=%0d: got y=%h ch=%0d v=%b wrap=%b err=%b, want y=00 ch=6 v=0 wrap=0 err=1",
                 k, y_b, ch_b, v_b, w_b, e_b);
      end
    end
    en_b = 1'b1;
    tick;
    checks++;
    if ({y_b, ch_b, v_b, w_b, e_b} !== {8'h33, 3'd2, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL hold_release_b: got y=%h ch=%0d v=%b wrap=%b err=%b, want y=33 ch=2 v=1 wrap=0 err=0",
               y_b, ch_b, v_b, w_b, e_b);
    end
  endtask

  task automatic test_edge_capture;
    s_a = 2'd1; en_a = 1'b1; mode_a = 1'b0;
    tick;
    checks++;
    if (y_a !== 1'b1) begin
      failures++;
      $display("FAIL edge_pre: got y=%b, want 1", y_a);
    end
    i_a = 4'b0000;
    #2;
    checks++;
    if (y_a !== 1'b1) begin
      failures++;
      $display("FAIL edge_between: got y=%b, want 1 (no capture before edge)", y_a);
    end
    tick;
    checks++;
    if (y_a !== 1'b0) begin
      failures++;
      $display("FAIL edge_post: got y=%b, want 0", y_a);
    end
    i_a = pat_a;
  endtask

  task automatic test_scan_dwell;
    int ech [10];
    ech = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
    mode_a = 1'b1; s_a = 2'd2; en_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      checks++;
      if ({y_a, ch_a, v_a, w_a, e_a} !== {pat_a[ech[k]], 2'(ech[k]), 1'b1, (k == 6), 1'b0}) begin
        failures++;
        $display("FAIL scan_dwell cyc=%0d: got y=%b ch=%0d v=%b wrap=%b err=%b, want y=%b ch=%0d v=1 wrap=%b err=0",
                 k, y_a, ch_a, v_a, w_a, e_a, pat_a[ech[k]], ech[k], (k == 6));
      end
    end
  endtask

  task automatic test_en_gap;
    logic ven [8];
    int   ech [8];
    ven = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ech = '{1, 1, 1, 1, 2, 2, 2, 3};
    for (int k = 0; k < 8; k++) begin
      en_a = ven[k];
      tick;
      checks++;
      if ({y_a, ch_a, v_a, w_a, e_a} !== {pat_a[ech[k]], 2'(ech[k]), ven[k], 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL en_gap cyc=%0d: got y=%b ch=%0d v=%b wrap=%b err=%b, want y=%b ch=%0d v=%b wrap=0 err=0",
                 k, y_a, ch_a, v_a, w_a, e_a, pat_a[ech[k]], ech[k], ven[k]);
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    int ech [4];
    ech = '{1, 1, 1, 2};
    rst = 1'b1;
    tick;
    checks++;
    if ({y_a, ch_a, v_a, w_a, e_a} !== 6'd0) begin
      failures++;
      $display("FAIL rst_mid_scan: got y=%b ch=%0d v=%b wrap=%b err=%b, want all 0", y_a, ch_a, v_a, w_a, e_a);
    end
    rst = 1'b0; mode_a = 1'b1; s_a = 2'd1; en_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if ({y_a, ch_a, v_a, w_a, e_a} !== {pat_a[ech[k]], 2'(ech[k]), 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL rst_restart cyc=%0d: got y=%b ch=%0d v=%b wrap=%b err=%b, want y=%b ch=%0d v=1 wrap=0 err=0",
                 k, y_a, ch_a, v_a, w_a, e_a, pat_a[ech[k]], ech[k]);
      end
    end
  endtask

  task automatic test_scan_b;
    int   ech [8];
    logic [2:0] sv [4];
    logic       mv [4];
    int   xc [4];
    logic [7:0] xy [4];
    logic       xe [4];
    ech = '{3, 4, 0, 1, 2, 3, 4, 0};
    mode_b = 1'b1; s_b = 3'd3; en_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      checks++;
      if ({y_b, ch_b, v_b, w_b, e_b} !== {chan_b[ech[k]], 3'(ech[k]), 1'b1, (ech[k] == 0), 1'b0}) begin
        failures++;
        $display("FAIL scan_b cyc=%0d: got y=%h ch=%0d v=%b wrap=%b err=%b, want y=%h ch=%0d v=1 wrap=%b err=0",
                 k, y_b, ch_b, v_b, w_b, e_b, chan_b[ech[k]], ech[k], (ech[k] == 0));
      end
    end
    sv = '{3'd2, 3'd7, 3'd7, 3'd7};
    mv = '{1'b0, 1'b0, 1'b1, 1'b1};
    xc = '{2, 7, 0, 1};
    xy = '{8'h33, 8'h00, 8'h11, 8'h22};
    xe = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      mode_b = mv[k]; s_b = sv[k];
      tick;
      checks++;
      if ({y_b, ch_b, v_b, w_b, e_b} !== {xy[k], 3'(xc[k]), 1'b1, 1'b0, xe[k]}) begin
        failures++;
        $display("FAIL mode_sw_b step=%0d: got y=%h ch=%0d v=%b wrap=%b err=%b, want y=%h ch=%0d v=1 wrap=0 err=%b",
                 k, y_b, ch_b, v_b, w_b, e_b, xy[k], xc[k], xe[k]);
      end
    end
  endtask

  initial begin
    chan_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int k = 0; k < 5; k++) i_b[k*8 +: 8] = chan_b[k];
    pat_a = 4'b1010;
    test_reset;
    test_manual_a;
    test_manual_b;
    test_hold;
    test_edge_capture;
    test_scan_dwell;
    test_en_gap;
    test_reset_mid_scan;
    test_scan_b;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
